// File: rtl/qr_pin_host.sv
// Host-side driver for the 8-pin ChaCha20 quarter-round test chip.
//
// The chip side protocol is as follows:
//
//   1. The pin clock (pin_in[0]) and write-enable (pin_in[1]) are bit-banged from clk.
//   2. The 128-bit {a,b,c,d} state is written to the chip as 32 nibbles, most significant first.
//   3. The 16 result bytes are then read back, one per pin period, by presenting the
//      byte index on the nibble lines.
//
// State table:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start; all pins low
//   S_WR_LO | write phase, pin clock low, nibble and we=1 set up
//   S_WR_HI | write phase, pin clock high, chip latches the nibble
//   S_RD_LO | read phase, pin clock low, byte index presented as sel
//   S_RD_HI | read phase, pin clock high; pin_out captured on the exit edge
//   S_DONE  | one-cycle done pulse with out_abcd freshly updated

module qr_pin_host #(
    parameter int HALF_PERIOD = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] in_abcd,
    output logic         busy,
    output logic         done,
    output logic [127:0] out_abcd,
    output logic [7:0]   pin_in,
    input  logic [7:0]   pin_out
);

    localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [PW-1:0] PH_RELOAD = PW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_LO = 3'd1,
        S_WR_HI = 3'd2,
        S_RD_LO = 3'd3,
        S_RD_HI = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [PW-1:0]  ph_cnt;
    logic           phase_end;
    logic [127:0]   sr;
    logic [127:0]   cap;
    logic [4:0]     nib_idx;
    logic [3:0]     byte_idx;

    // A phase ends when its down-counter has reached terminal count.
    assign phase_end = (ph_cnt == '0);

    // Next-state decode: phases advance only at terminal count.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WR_LO;
            S_WR_LO: if (phase_end) state_nxt = S_WR_HI;
            S_WR_HI: if (phase_end) state_nxt = (nib_idx == 5'd31) ? S_RD_LO : S_WR_LO;
            S_RD_LO: if (phase_end) state_nxt = S_RD_HI;
            S_RD_HI: if (phase_end) state_nxt = (byte_idx == 4'd15) ? S_DONE : S_RD_LO;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: pins depend only on registered state, so they are
    // low whenever the FSM is outside the write/read loops.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        pin_in = 8'h00;
        case (state)
            S_WR_LO: begin
                busy   = 1'b1;
                pin_in = {sr[127:124], 2'b00, 1'b1, 1'b0};
            end
            S_WR_HI: begin
                busy   = 1'b1;
                pin_in = {sr[127:124], 2'b00, 1'b1, 1'b1};
            end
            S_RD_LO: begin
                busy   = 1'b1;
                pin_in = {byte_idx, 2'b00, 1'b0, 1'b0};
            end
            S_RD_HI: begin
                busy   = 1'b1;
                pin_in = {byte_idx, 2'b00, 1'b0, 1'b1};
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // State register plus datapath: phase timer, write shifter, read capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ph_cnt   <= '0;
            sr       <= '0;
            cap      <= '0;
            out_abcd <= '0;
            nib_idx  <= '0;
            byte_idx <= '0;
        end else begin
            state <= state_nxt;

            // Reload on every phase change so each phase lasts HALF_PERIOD cycles.
            if (state_nxt != state) begin
                ph_cnt <= PH_RELOAD;
            end else if (!phase_end) begin
                ph_cnt <= ph_cnt - PW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        sr       <= in_abcd;
                        cap      <= '0;
                        nib_idx  <= '0;
                        byte_idx <= '0;
                    end
                end
                S_WR_HI: begin
                    // Shifting on the HI->LO edge keeps data stable across the rising pin edge.
                    if (phase_end) begin
                        sr      <= {sr[123:0], 4'h0};
                        nib_idx <= nib_idx + 5'd1;
                    end
                end
                S_RD_HI: begin
                    if (phase_end) begin
                        cap[{byte_idx, 3'b000} +: 8] <= pin_out;
                        byte_idx                     <= byte_idx + 4'd1;
                        // The result register is loaded whole, never byte by byte.
                        if (byte_idx == 4'd15) begin
                            out_abcd <= {pin_out, cap[119:0]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
